cic_sample_fifo: RTL and testbench

CIC_SAMPLE_FIFO -- requirements
Module: cic_sample_fifo

---
 rtl/cic_sample_fifo.sv | 124 ++++++++++++
 tb/tb_cic_sample_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic_sample_fifo.sv
// Sample FIFO between a CIC decimator and its consumer; one write per rising edge of cic_clk_i.
// Optional macro CIC_SAMPLE_FIFO_DROP_CNT_EN adds a saturating 16-bit dropped-sample counter.
module cic_sample_fifo #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   cic_data_i,
  input  logic                    cic_clk_i,
  input  logic                    clear_i,
  input  logic                    sample_ready_i,
  output logic [DATA_WIDTH-1:0]   sample_data_o,
  output logic                    sample_valid_o,
  output logic [$clog2(DEPTH):0]  fill_level_o,
`ifdef CIC_SAMPLE_FIFO_DROP_CNT_EN
  output logic [15:0]             drop_count_o,
`endif
  output logic                    overflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic                  cic_clk_q, cic_clk_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic                  overflow_q, overflow_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic rise_c;
  logic pop_c;
  logic wr_en_c;

  // Strobe edge detect and handshake qualification; clear suppresses both sides.
  always_comb begin
    rise_c  = cic_clk_i & ~cic_clk_q;
    pop_c   = valid_q & sample_ready_i & ~clear_i;
    wr_en_c = rise_c & ~clear_i & ((fill_q != CW'(DEPTH)) | pop_c);
  end

  // Pointer, level and status next-state.
  always_comb begin
    cic_clk_d  = cic_clk_i;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en_c, pop_c})
        2'b10:   fill_d = fill_q + CW'(1);
        2'b01:   fill_d = fill_q - CW'(1);
        default: fill_d = fill_q;
      endcase
      overflow_d = overflow_q | (rise_c & ~wr_en_c);
    end
    valid_d = (fill_d != '0);
  end

  // Storage write port.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_c) mem_d[wr_ptr_q] = cic_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cic_clk_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      cic_clk_q  <= cic_clk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  // Sample storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifdef CIC_SAMPLE_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      drop_cnt_d = '0;
    end else if (rise_c & ~wr_en_c & ~(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + 16'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_o = drop_cnt_q;
`endif

  assign sample_data_o  = mem_q[rd_ptr_q];
  assign sample_valid_o = valid_q;
  assign fill_level_o   = fill_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_cic_sample_fifo.sv
// Self-checking bench for cic_sample_fifo: vector table, directed corner sequences, random vs. queue model.
module tb_cic_sample_fifo;

  localparam int DW    = 20;
  localparam int DEPTH = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] cic_data_i = '0;
  logic          cic_clk_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          sample_ready_i = 1'b0;
  logic [DW-1:0] sample_data_o;
  logic          sample_valid_o;
  logic [3:0]    fill_level_o;
  logic          overflow_o;
`ifdef CIC_SAMPLE_FIFO_DROP_CNT_EN
  logic [15:0]   drop_count_o;
`endif

  cic_sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cic_data_i     (cic_data_i),
    .cic_clk_i      (cic_clk_i),
    .clear_i        (clear_i),
    .sample_ready_i (sample_ready_i),
    .sample_data_o  (sample_data_o),
    .sample_valid_o (sample_valid_o),
    .fill_level_o   (fill_level_o),
`ifdef CIC_SAMPLE_FIFO_DROP_CNT_EN
    .drop_count_o   (drop_count_o),
`endif
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of stored samples plus status.
  logic [DW-1:0] m_q [$];
  logic          m_ovf;
  int            m_drop;
  logic          m_prev;
  logic [DW-1:0] got [$];

  typedef struct {
    logic          cic;
    logic [DW-1:0] d;
    logic          rdy;
    logic          clr;
    int            fill;
    logic          vld;
    logic          ovf;
    logic [DW-1:0] head;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    m_prev = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    got.delete();
  endtask

  // One clock: apply inputs, check any pop against the model, advance, compare status.
  task automatic cyc(input logic cic, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic rise;
    cic_clk_i      = cic;
    cic_data_i     = d;
    sample_ready_i = rdy;
    clear_i        = clr;
    rise = cic && !m_prev;
    if (!clr && rdy && m_q.size() != 0) begin
      chk("pop_data", 32'(sample_data_o), 32'(m_q[0]));
      got.push_back(sample_data_o);
    end
    @(posedge clk_i); #1;
    if (clr) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (rise) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
    m_prev = cic;
    chk("fill", 32'(fill_level_o), 32'(m_q.size()));
    chk("valid", 32'(sample_valid_o), 32'(m_q.size() != 0));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    if (m_q.size() != 0) chk("head", 32'(sample_data_o), 32'(m_q[0]));
`ifdef CIC_SAMPLE_FIFO_DROP_CNT_EN
    chk("drop_count", 32'(drop_count_o), 32'(m_drop));
`endif
  endtask

  task automatic rise_with(input logic [DW-1:0] d, input logic rdy);
    cyc(1'b1, d, rdy, 1'b0);
    cyc(1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 20'h12345, 1'b0, 1'b0, 1, 1'b1, 1'b0, 20'h12345};
    tbl[1]  = '{1'b0, 20'h00000, 1'b0, 1'b0, 1, 1'b1, 1'b0, 20'h12345};
    tbl[2]  = '{1'b0, 20'h00000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 20'h00000};
    tbl[3]  = '{1'b1, 20'h0000A, 1'b0, 1'b0, 1, 1'b1, 1'b0, 20'h0000A};
    tbl[4]  = '{1'b0, 20'h00000, 1'b0, 1'b0, 1, 1'b1, 1'b0, 20'h0000A};
    tbl[5]  = '{1'b1, 20'h0000B, 1'b0, 1'b0, 2, 1'b1, 1'b0, 20'h0000A};
    tbl[6]  = '{1'b0, 20'h00000, 1'b0, 1'b0, 2, 1'b1, 1'b0, 20'h0000A};
    tbl[7]  = '{1'b1, 20'h0000C, 1'b1, 1'b0, 2, 1'b1, 1'b0, 20'h0000B};
    tbl[8]  = '{1'b0, 20'h00000, 1'b1, 1'b0, 1, 1'b1, 1'b0, 20'h0000C};
    tbl[9]  = '{1'b1, 20'h0000D, 1'b0, 1'b1, 0, 1'b0, 1'b0, 20'h00000};
    tbl[10] = '{1'b1, 20'h0000E, 1'b0, 1'b0, 0, 1'b0, 1'b0, 20'h00000};
    tbl[11] = '{1'b0, 20'h00000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 20'h00000};

    model_reset();
    @(posedge clk_i); #1;
    do_reset();
    chk("reset_fill", 32'(fill_level_o), 32'd0);
    chk("reset_valid", 32'(sample_valid_o), 32'd0);
    chk("reset_ovf", 32'(overflow_o), 32'd0);

    // Vector table: single sample, hold, pop, concurrent push/pop, clear, held strobe after clear.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].cic, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_fill", i), 32'(fill_level_o), 32'(tbl[i].fill));
      chk($sformatf("tbl%0d_valid", i), 32'(sample_valid_o), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow_o), 32'(tbl[i].ovf));
      if (tbl[i].vld) chk($sformatf("tbl%0d_head", i), 32'(sample_data_o), 32'(tbl[i].head));
    end

    // Ordering and wrap with random ready gaps.
    do_reset();
    for (int i = 1; i <= 20; i++) rise_with(DW'(i), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 24 && m_q.size() != 0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("order_count", 32'(got.size()), 32'd20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("order_val", 32'(got[i]), 32'(i + 1));
    chk("order_ovf", 32'(overflow_o), 32'd0);

    // Overflow: 10 writes into depth 8, then drain.
    do_reset();
    for (int i = 1; i <= 10; i++) rise_with(DW'(i), 1'b0);
    chk("ovf_fill", 32'(fill_level_o), 32'd8);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_head", 32'(sample_data_o), 32'd1);
`ifdef CIC_SAMPLE_FIFO_DROP_CNT_EN
    chk("ovf_drops", 32'(drop_count_o), 32'd2);
`endif
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("ovf_drain_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("ovf_drain_val", 32'(got[i]), 32'(i + 1));
    chk("ovf_sticky", 32'(overflow_o), 32'd1);

    // Full FIFO with write and pop in the same cycle.
    do_reset();
    for (int i = 1; i <= 8; i++) rise_with(DW'(i), 1'b0);
    cyc(1'b1, DW'(9), 1'b1, 1'b0);
    chk("fullpop_fill", 32'(fill_level_o), 32'd8);
    chk("fullpop_ovf", 32'(overflow_o), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    got.delete();
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("fullpop_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("fullpop_val", 32'(got[i]), 32'(i + 2));

    // Clear coincident with a rise, 3 samples stored.
    do_reset();
    for (int i = 1; i <= 3; i++) rise_with(DW'(i), 1'b0);
    cyc(1'b1, DW'(4), 1'b0, 1'b1);
    chk("clear_fill", 32'(fill_level_o), 32'd0);
    chk("clear_ovf", 32'(overflow_o), 32'd0);
    chk("clear_valid", 32'(sample_valid_o), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with 5 samples stored.
    for (int i = 1; i <= 5; i++) rise_with(DW'(i), 1'b0);
    chk("prerst_fill", 32'(fill_level_o), 32'd5);
    rst_i = 1'b1;
    #1;
    chk("rst_async_valid", 32'(sample_valid_o), 32'd0);
    chk("rst_async_fill", 32'(fill_level_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();

    // Strobe high through reset release and held for 50 cycles: exactly one write.
    cic_clk_i = 1'b1;
    do_reset();
    for (int i = 0; i < 50; i++) cyc(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    chk("held_fill", 32'(fill_level_o), 32'd1);
    chk("held_head", 32'(sample_data_o), 32'h100);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 2) == 0), DW'($urandom), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
